// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if: packet request and UART byte-load signals for uart_packet_tx
interface uart_packet_tx_if #(
    parameter int MAX_LEN = 8
);
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [7:0]             pkt_type;
    logic [3:0]             pkt_len;
    logic [8*MAX_LEN-1:0]   pkt_data;
    logic                   ld_tx_data;
    logic [7:0]             tx_data;
    logic                   tx_empty;
    logic                   busy;
    logic                   pkt_done;
    logic                   len_err;
    logic                   timeout_err;

    modport master (
        output pkt_valid, pkt_type, pkt_len, pkt_data, tx_empty,
        input  pkt_ready, ld_tx_data, tx_data, busy, pkt_done, len_err, timeout_err
    );

    modport slave (
        input  pkt_valid, pkt_type, pkt_len, pkt_data, tx_empty,
        output pkt_ready, ld_tx_data, tx_data, busy, pkt_done, len_err, timeout_err
    );
endinterface

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: frames one event message as SOF, TYPE, LEN, DATA..., CHK onto a UART byte-load port
module uart_packet_tx #(
    parameter int          MAX_LEN     = 8,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic            txclk,
    input  logic            reset_n,
    uart_packet_tx_if.slave bus
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t               r_state, w_state;
    logic [7:0]           r_type, w_type;
    logic [3:0]           r_len, w_len;
    logic [8*MAX_LEN-1:0] r_data, w_data;
    logic [4:0]           r_idx, w_idx;
    logic [7:0]           r_chk, w_chk;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [7:0]           r_tx_data, w_tx_data;
    logic                 r_ld, w_ld;
    logic                 r_done, w_done;
    logic                 r_len_err, w_len_err;
    logic                 r_to, w_to;
    logic [4:0]           w_last;
    logic [7:0]           w_byte;

    // payload is shifted down as each data byte is taken, so the current data byte is always the low byte
    assign w_last = {1'b0, r_len} + 5'd3;
    assign w_byte = (r_idx == 5'd0)   ? SOF_BYTE :
                    (r_idx == 5'd1)   ? r_type :
                    (r_idx == 5'd2)   ? {4'h0, r_len} :
                    (r_idx == w_last) ? r_chk : r_data[7:0];

    assign bus.pkt_ready   = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.ld_tx_data  = r_ld;
    assign bus.tx_data     = r_tx_data;
    assign bus.pkt_done    = r_done;
    assign bus.len_err     = r_len_err;
    assign bus.timeout_err = r_to;

    // next-state and next-output logic: accept, present a byte, wait for the UART to take it
    always_comb begin
        w_state   = r_state;
        w_type    = r_type;
        w_len     = r_len;
        w_data    = r_data;
        w_idx     = r_idx;
        w_chk     = r_chk;
        w_cnt     = r_cnt;
        w_tx_data = r_tx_data;
        w_ld      = 1'b0;
        w_done    = 1'b0;
        w_len_err = 1'b0;
        w_to      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (bus.pkt_len > 4'(MAX_LEN)) begin
                        w_len_err = 1'b1;
                    end else begin
                        w_type  = bus.pkt_type;
                        w_len   = bus.pkt_len;
                        w_data  = bus.pkt_data;
                        w_idx   = 5'd0;
                        w_chk   = 8'h00;
                        w_state = LOAD;
                    end
                end
            end
            LOAD: begin
                w_tx_data = w_byte;
                if (bus.tx_empty) begin
                    w_ld    = 1'b1;
                    w_cnt   = '0;
                    w_state = ACK;
                end
            end
            ACK: begin
                if (!bus.tx_empty) begin
                    if (r_idx == w_last) begin
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_idx   = r_idx + 5'd1;
                        w_chk   = (r_idx != 5'd0) ? r_chk + r_tx_data : r_chk;
                        w_data  = (r_idx >= 5'd3) ? r_data >> 8 : r_data;
                        w_state = LOAD;
                    end
                end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_to    = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any partial frame
    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_type    <= '0;
            r_len     <= '0;
            r_data    <= '0;
            r_idx     <= '0;
            r_chk     <= '0;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_ld      <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_type    <= w_type;
            r_len     <= w_len;
            r_data    <= w_data;
            r_idx     <= w_idx;
            r_chk     <= w_chk;
            r_cnt     <= w_cnt;
            r_tx_data <= w_tx_data;
            r_ld      <= w_ld;
            r_done    <= w_done;
            r_len_err <= w_len_err;
            r_to      <= w_to;
        end
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: randomized frame checks of uart_packet_tx against a queue-based frame model and a UART model
module tb_uart_packet_tx;
    localparam int MAX_LEN     = 8;
    localparam int ACK_TIMEOUT = 16;

    logic txclk   = 1'b0;
    logic reset_n = 1'b0;

    uart_packet_tx_if #(.MAX_LEN(MAX_LEN)) bus();

    uart_packet_tx #(
        .MAX_LEN(MAX_LEN),
        .SOF_BYTE(8'hA5),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .txclk(txclk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 txclk = ~txclk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got[$];
    int         cyc = 0, n_ld = 0, n_done = 0, n_lerr = 0, n_to = 0, consec = 0, bsy = 0;
    int         ld_cyc = 0, take_cyc = 0, done_cyc = 0, to_cyc = 0;
    bit         stall = 0, prev_ld = 0;

    // UART holding-register model and event monitor, evaluated on the falling edge
    always @(negedge txclk) begin
        cyc++;
        if (!reset_n) begin
            bus.tx_empty = 1'b1;
            bsy = 0;
            prev_ld = 0;
        end else begin
            if (bus.ld_tx_data) begin
                got.push_back(bus.tx_data);
                n_ld++;
                ld_cyc = cyc;
                if (prev_ld) consec++;
                if (!stall) begin
                    bus.tx_empty = 1'b0;
                    bsy = int'($urandom_range(1, 6));
                    take_cyc = cyc;
                end
            end else if (bsy > 0) begin
                bsy--;
                if (bsy == 0) bus.tx_empty = 1'b1;
            end
            prev_ld = bus.ld_tx_data;
            if (bus.pkt_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.len_err) n_lerr++;
            if (bus.timeout_err) begin
                n_to++;
                to_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge txclk);
            #1;
        end
    endtask

    task automatic build_exp(input logic [7:0] t, input logic [3:0] l,
                             input logic [8*MAX_LEN-1:0] d, output logic [7:0] q[$]);
        int s;
        q.delete();
        q.push_back(8'hA5);
        q.push_back(t);
        q.push_back({4'h0, l});
        s = int'(t) + int'(l);
        for (int i = 0; i < int'(l); i++) begin
            q.push_back(d[8*i +: 8]);
            s += int'(d[8*i +: 8]);
        end
        q.push_back(8'(s % 256));
    endtask

    task automatic issue(input logic [7:0] t, input logic [3:0] l, input logic [8*MAX_LEN-1:0] d);
        int k;
        k = 0;
        while (!bus.pkt_ready && k < 100) begin
            tick(1);
            k++;
        end
        bus.pkt_type  = t;
        bus.pkt_len   = l;
        bus.pkt_data  = d;
        bus.pkt_valid = 1'b1;
        tick(1);
        bus.pkt_valid = 1'b0;
    endtask

    task automatic run_pkt(input string name, input logic [7:0] t, input logic [3:0] l,
                           input logic [8*MAX_LEN-1:0] d, input bit poke);
        logic [7:0] exp[$];
        int ld0, d0, k;
        bit ok;
        build_exp(t, l, d, exp);
        got.delete();
        ld0 = n_ld;
        d0  = n_done;
        issue(t, l, d);
        if (poke) begin
            tick(3);
            bus.pkt_type  = 8'h55;
            bus.pkt_len   = 4'd1;
            bus.pkt_data  = ~d;
            bus.pkt_valid = 1'b1;
            tick(1);
            bus.pkt_valid = 1'b0;
        end
        k = 0;
        while (n_done == d0 && k < 2000) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (n_done != d0 + 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d expected %0d", name, n_done - d0, 1);
        end
        n_checks++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s frame_len: got %0d expected %0d", name, got.size(), exp.size());
        end
        ok = 1;
        foreach (exp[i]) if (i >= got.size() || got[i] !== exp[i]) ok = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s frame: got %p expected %p", name, got, exp);
        end
        n_checks++;
        if (done_cyc - take_cyc != 1) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d expected 1", name, done_cyc - take_cyc);
        end
        tick(1);
        n_checks++;
        if (bus.pkt_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_after: got ready=%b busy=%b expected ready=1 busy=0", name, bus.pkt_ready, bus.busy);
        end
        tick(20);
        n_checks++;
        if (n_ld - ld0 != exp.size() || n_done != d0 + 1) begin
            n_fail++;
            $display("FAIL %s load_count: got loads=%0d dones=%0d expected loads=%0d dones=1", name, n_ld - ld0, n_done - d0, exp.size());
        end
        n_checks++;
        if (consec != 0) begin
            n_fail++;
            $display("FAIL %s ld_back_to_back: got %0d expected 0", name, consec);
        end
    endtask

    task automatic test_reset;
        tick(2);
        n_checks++;
        if (bus.pkt_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready_busy: got %b%b expected 10", bus.pkt_ready, bus.busy);
        end
        n_checks++;
        if (bus.ld_tx_data !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset load: got ld=%b data=%h expected ld=0 data=00", bus.ld_tx_data, bus.tx_data);
        end
        n_checks++;
        if ({bus.pkt_done, bus.len_err, bus.timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset pulses: got %b expected 000", {bus.pkt_done, bus.len_err, bus.timeout_err});
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        run_pkt("basic", 8'h01, 4'd2, 64'h2010, 1'b0);
    endtask

    task automatic test_len0;
        run_pkt("len0", 8'h07, 4'd0, 64'h0, 1'b0);
    endtask

    task automatic test_wrap;
        run_pkt("wrap", 8'hFF, 4'd1, 64'h02, 1'b0);
        run_pkt("maxlen", 8'hFF, 4'd8, {8{8'hFF}}, 1'b0);
    endtask

    task automatic test_len_err;
        int ld0, le0;
        ld0 = n_ld;
        le0 = n_lerr;
        issue(8'h42, 4'd9, 64'h1234);
        tick(3);
        n_checks++;
        if (n_lerr != le0 + 1) begin
            n_fail++;
            $display("FAIL len_err pulse_cycles: got %0d expected 1", n_lerr - le0);
        end
        n_checks++;
        if (n_ld != ld0 || bus.pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len_err idle: got loads=%0d ready=%b expected loads=0 ready=1", n_ld - ld0, bus.pkt_ready);
        end
        issue(8'h42, 4'd15, 64'h1234);
        tick(3);
        n_checks++;
        if (n_lerr != le0 + 2 || n_ld != ld0) begin
            n_fail++;
            $display("FAIL len_err len15: got errs=%0d loads=%0d expected errs=2 loads=0", n_lerr - le0, n_ld - ld0);
        end
    endtask

    task automatic test_busy_ignore;
        run_pkt("busy_ignore", 8'h3C, 4'd3, 64'hC0FFEE, 1'b1);
    endtask

    task automatic test_timeout;
        int ld0, to0, k;
        ld0 = n_ld;
        to0 = n_to;
        stall = 1;
        issue(8'h33, 4'd2, 64'hABCD);
        k = 0;
        while (n_to == to0 && k < 200) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (n_to != to0 + 1) begin
            n_fail++;
            $display("FAIL timeout pulse: got %0d expected 1", n_to - to0);
        end
        n_checks++;
        if (to_cyc - ld_cyc != ACK_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout latency: got %0d expected %0d", to_cyc - ld_cyc, ACK_TIMEOUT);
        end
        tick(1);
        n_checks++;
        if (bus.pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout idle: got ready=%b expected 1", bus.pkt_ready);
        end
        tick(30);
        n_checks++;
        if (n_ld - ld0 != 1 || n_to != to0 + 1) begin
            n_fail++;
            $display("FAIL timeout loads: got loads=%0d errs=%0d expected loads=1 errs=1", n_ld - ld0, n_to - to0);
        end
        stall = 0;
        tick(2);
    endtask

    task automatic test_reset_mid;
        int k;
        got.delete();
        issue(8'h9A, 4'd3, 64'h332211);
        k = 0;
        while (got.size() < 5 && k < 500) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (got.size() < 5) begin
            n_fail++;
            $display("FAIL reset_mid reach_data1: got %0d bytes expected 5", got.size());
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pkt_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ld_tx_data !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.pkt_done !== 1'b0 || bus.timeout_err !== 1'b0 || bus.len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got ready=%b busy=%b ld=%b data=%h expected 1 0 0 00", bus.pkt_ready, bus.busy, bus.ld_tx_data, bus.tx_data);
        end
        tick(2);
        reset_n = 1'b1;
        tick(2);
        run_pkt("after_reset", 8'h9A, 4'd3, 64'h332211, 1'b0);
    endtask

    task automatic test_random;
        logic [3:0] l;
        logic [7:0] t;
        logic [8*MAX_LEN-1:0] d;
        for (int i = 0; i < 12; i++) begin
            l = 4'($urandom_range(0, MAX_LEN));
            t = 8'($urandom);
            d = {$urandom, $urandom};
            run_pkt($sformatf("random%0d", i), t, l, d, i[0]);
        end
    endtask

    initial begin
        bus.pkt_valid = 1'b0;
        bus.pkt_type  = 8'h00;
        bus.pkt_len   = 4'h0;
        bus.pkt_data  = '0;
        test_reset;
        test_basic;
        test_len0;
        test_wrap;
        test_len_err;
        test_busy_ignore;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
